// File: rtl/NanoCore_pkg.sv
// Shared NanoCore types for the fetch / execute / BTB interfaces.
package NanoCore_pkg;

    localparam int unsigned btb_entries_default = 8;

    // Resolution update returned by execute.
    typedef struct packed {
        logic        valid;
        logic        is_jarl;
        logic [31:0] pc;
        logic [31:0] tgt;
    } btb_t;

    // Prediction handed to fetch and carried down the pipe.
    typedef struct packed {
        logic        jump;
        logic [31:0] tgt;
        logic [31:0] pc;
    } btb_ctl_t;

endpackage

// File: rtl/n2_btb_if.sv
// Lookup and update channels between fetch/execute (master) and the BTB (slave).
interface n2_btb_if;
    import NanoCore_pkg::*;

    logic        lookup_v_i;
    logic [31:0] lookup_pc_i;
    btb_ctl_t    btb_ctl_o;
    logic        btb_upd_v_i;
    btb_t        btb_upd_info_i;

    modport master (
        output lookup_v_i,
        output lookup_pc_i,
        output btb_upd_v_i,
        output btb_upd_info_i,
        input  btb_ctl_o
    );

    modport slave (
        input  lookup_v_i,
        input  lookup_pc_i,
        input  btb_upd_v_i,
        input  btb_upd_info_i,
        output btb_ctl_o
    );
endinterface

// File: rtl/n2_btb_match.sv
// Combinational CAM compare: one-hot hit vector and encoded index for a key PC.
module n2_btb_match
    import NanoCore_pkg::*;
#(
    parameter  int unsigned Entries = btb_entries_default,
    localparam int unsigned IdxW    = $clog2(Entries)
) (
    input  logic [Entries-1:0]       valid_i,
    input  logic [Entries-1:0][31:0] tag_i,
    input  logic [31:0]              key_i,
    output logic [Entries-1:0]       hit_vec_o,
    output logic [IdxW-1:0]          hit_idx_o
);

    // Parallel tag compare against every valid entry.
    always_comb begin
        hit_vec_o = '0;
        for (int unsigned i = 0; i < Entries; i++) begin
            hit_vec_o[i] = valid_i[i] && (tag_i[i] == key_i);
        end
    end

    // Encode the hit; at most one entry can match, so OR-ing indices is safe.
    always_comb begin
        hit_idx_o = '0;
        for (int unsigned i = 0; i < Entries; i++) begin
            if (hit_vec_o[i]) begin
                hit_idx_o = hit_idx_o | IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/n2_btb.sv
// Fully associative branch target buffer: lookup, allocate, replace, invalidate, flush.
module n2_btb
    import NanoCore_pkg::*;
#(
    parameter  int unsigned BTB_ENTRIES = btb_entries_default,
    localparam int unsigned IdxW        = $clog2(BTB_ENTRIES),
    localparam int unsigned CntW        = $clog2(BTB_ENTRIES) + 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush_i,
    n2_btb_if.slave         btb_if,
    output logic [CntW-1:0] occupancy_o
);

    logic [BTB_ENTRIES-1:0]       valid_q, valid_d;
    logic [BTB_ENTRIES-1:0]       jarl_q, jarl_d;
    logic [BTB_ENTRIES-1:0][31:0] pc_q, pc_d;
    logic [BTB_ENTRIES-1:0][31:0] tgt_q, tgt_d;
    logic [IdxW-1:0]              rr_ptr_q, rr_ptr_d;
    btb_ctl_t                     ctl_q, ctl_d;
    logic [CntW-1:0]              occ_q, occ_d;

    logic [BTB_ENTRIES-1:0] lk_vec, up_vec;
    logic [IdxW-1:0]        lk_idx, up_idx;
    logic                   lk_hit, up_hit;
    logic                   free_found;
    logic [IdxW-1:0]        free_idx;
    logic [IdxW-1:0]        wr_idx;
    btb_t                   upd;

    // is_jarl is kept in the table for a future return-stack predictor.
    logic unused_jarl;
    assign unused_jarl = ^jarl_q;

    assign upd = btb_if.btb_upd_info_i;

    n2_btb_match #(.Entries(BTB_ENTRIES)) u_match_lookup (
        .valid_i   (valid_q),
        .tag_i     (pc_q),
        .key_i     (btb_if.lookup_pc_i),
        .hit_vec_o (lk_vec),
        .hit_idx_o (lk_idx)
    );

    n2_btb_match #(.Entries(BTB_ENTRIES)) u_match_update (
        .valid_i   (valid_q),
        .tag_i     (pc_q),
        .key_i     (upd.pc),
        .hit_vec_o (up_vec),
        .hit_idx_o (up_idx)
    );

    assign lk_hit = |lk_vec;
    assign up_hit = |up_vec;

    // Lowest-index invalid entry; scanning downward lets the lowest one win.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = BTB_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
        end
    end

    // Hit rewrites in place, otherwise a free slot, otherwise the round-robin victim.
    always_comb begin
        if (up_hit) begin
            wr_idx = up_idx;
        end else if (free_found) begin
            wr_idx = free_idx;
        end else begin
            wr_idx = rr_ptr_q;
        end
    end

    // Table next state: flush beats update.
    always_comb begin
        valid_d  = valid_q;
        jarl_d   = jarl_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        rr_ptr_d = rr_ptr_q;
        if (flush_i) begin
            valid_d  = '0;
            rr_ptr_d = '0;
        end else if (btb_if.btb_upd_v_i) begin
            if (upd.valid) begin
                valid_d[wr_idx] = 1'b1;
                jarl_d[wr_idx]  = upd.is_jarl;
                pc_d[wr_idx]    = upd.pc;
                tgt_d[wr_idx]   = upd.tgt;
                if (!up_hit && !free_found) begin
                    rr_ptr_d = rr_ptr_q + IdxW'(1);
                end
            end else begin
                valid_d = valid_q & ~up_vec;
            end
        end
    end

    // Prediction next state, with same-PC update bypass; held when fetch stalls.
    always_comb begin
        ctl_d = ctl_q;
        if (btb_if.lookup_v_i) begin
            ctl_d.pc   = btb_if.lookup_pc_i;
            ctl_d.jump = 1'b0;
            ctl_d.tgt  = '0;
            if (flush_i) begin
                ctl_d.jump = 1'b0;
            end else if (btb_if.btb_upd_v_i && (upd.pc == btb_if.lookup_pc_i)) begin
                if (upd.valid) begin
                    ctl_d.jump = 1'b1;
                    ctl_d.tgt  = upd.tgt;
                end
            end else if (lk_hit) begin
                ctl_d.jump = 1'b1;
                ctl_d.tgt  = tgt_q[lk_idx];
            end
        end
    end

    // Population count of the next valid vector.
    always_comb begin
        occ_d = '0;
        for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
            occ_d = occ_d + CntW'(valid_d[i]);
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q  <= '0;
            jarl_q   <= '0;
            rr_ptr_q <= '0;
            ctl_q    <= '0;
            occ_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            jarl_q   <= jarl_d;
            rr_ptr_q <= rr_ptr_d;
            ctl_q    <= ctl_d;
            occ_q    <= occ_d;
        end
    end

    // Tag and target storage; contents are meaningless until valid is set.
    always_ff @(posedge clk) begin
        pc_q  <= pc_d;
        tgt_q <= tgt_d;
    end

    assign btb_if.btb_ctl_o = ctl_q;
    assign occupancy_o      = occ_q;

endmodule

// File: tb/tb_n2_btb.sv
// Scoreboard bench for n2_btb against a table-level reference model.
module tb_n2_btb;
    import NanoCore_pkg::*;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       flush;
    logic [3:0] occ;

    n2_btb_if bif ();

    n2_btb #(.BTB_ENTRIES(N)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush_i     (flush),
        .btb_if      (bif),
        .occupancy_o (occ)
    );

    always #5 clk = ~clk;

    typedef struct {
        btb_ctl_t ctl;
        int       occ;
    } exp_t;

    exp_t     sb[$];
    int       passed = 0;
    int       total  = 0;

    // Reference table: a set of (pc, tgt) mappings plus an eviction cursor.
    bit          mv[N];
    logic [31:0] mpc[N];
    logic [31:0] mtgt[N];
    int          rr;
    btb_ctl_t    mctl;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int mfind(input logic [31:0] pc);
        for (int i = 0; i < N; i++) if (mv[i] && mpc[i] == pc) return i;
        return -1;
    endfunction

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < N; i++) if (mv[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mv[i] = 1'b0;
        rr   = 0;
        mctl = '0;
    endtask

    task automatic idle();
        flush               = 1'b0;
        bif.lookup_v_i      = 1'b0;
        bif.lookup_pc_i     = '0;
        bif.btb_upd_v_i     = 1'b0;
        bif.btb_upd_info_i  = '0;
    endtask

    // One cycle of stimulus; called right after a falling edge.
    task automatic step(input bit f, input bit lv, input logic [31:0] lpc,
                        input bit uv, input bit uval, input logic [31:0] upc,
                        input logic [31:0] utgt);
        int   k;
        exp_t e;
        flush                      = f;
        bif.lookup_v_i             = lv;
        bif.lookup_pc_i            = lpc;
        bif.btb_upd_v_i            = uv;
        bif.btb_upd_info_i.valid   = uval;
        bif.btb_upd_info_i.is_jarl = 1'($urandom);
        bif.btb_upd_info_i.pc      = upc;
        bif.btb_upd_info_i.tgt     = utgt;
        // Prediction: the table as it stands, except a same-PC update is seen already.
        if (lv) begin
            mctl.pc   = lpc;
            mctl.jump = 1'b0;
            mctl.tgt  = '0;
            if (!f) begin
                if (uv && upc == lpc) begin
                    if (uval) begin
                        mctl.jump = 1'b1;
                        mctl.tgt  = utgt;
                    end
                end else begin
                    k = mfind(lpc);
                    if (k >= 0) begin
                        mctl.jump = 1'b1;
                        mctl.tgt  = mtgt[k];
                    end
                end
            end
        end
        // Table change.
        if (f) begin
            for (int i = 0; i < N; i++) mv[i] = 1'b0;
            rr = 0;
        end else if (uv) begin
            k = mfind(upc);
            if (uval) begin
                if (k >= 0) begin
                    mtgt[k] = utgt;
                end else begin
                    for (int i = N - 1; i >= 0; i--) if (!mv[i]) k = i;
                    if (k < 0) begin
                        k  = rr;
                        rr = (rr + 1) % N;
                    end
                    mv[k]   = 1'b1;
                    mpc[k]  = upc;
                    mtgt[k] = utgt;
                end
            end else if (k >= 0) begin
                mv[k] = 1'b0;
            end
        end
        e.ctl = mctl;
        e.occ = mcount();
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic look(input logic [31:0] pc);
        step(1'b0, 1'b1, pc, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic upd(input bit val, input logic [31:0] pc, input logic [31:0] tgt);
        step(1'b0, 1'b0, 32'h0, 1'b1, val, pc, tgt);
    endtask

    // Monitor: every registered output is compared one step after its stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("btb_ctl", bif.btb_ctl_o, e.ctl);
                chk("occupancy", occ, 128'(e.occ));
            end
        end
    end

    initial begin
        logic [31:0] lpc, upc;
        idle();
        model_reset();
        #3;
        chk("reset_ctl", bif.btb_ctl_o, 128'h0);
        chk("reset_occ", occ, 128'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Cold miss, allocate, hit, invalidate.
        look(32'h100);
        upd(1'b1, 32'h100, 32'h180);
        look(32'h100);
        upd(1'b0, 32'h100, 32'h0);
        look(32'h100);

        // Fill, evict three, then wrap the cursor.
        for (int i = 0; i < 8; i++) upd(1'b1, 32'(i * 4), 32'h1000 + 32'(i));
        for (int i = 0; i < 3; i++) upd(1'b1, 32'h200 + 32'(i * 4), 32'h2000 + 32'(i));
        for (int i = 0; i < 4; i++) look(32'(i * 4));
        for (int i = 0; i < 8; i++) upd(1'b1, 32'h300 + 32'(i * 4), 32'h3000 + 32'(i));
        for (int i = 0; i < 8; i++) look(32'h300 + 32'(i * 4));
        upd(1'b1, 32'h400, 32'h4000);
        look(32'h30C);
        look(32'h310);

        // Same-cycle bypass, valid then invalidating.
        step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 32'h90);
        look(32'h40);
        step(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h40, 32'h0);
        look(32'h40);

        // Stall holds the prediction, then flush drops a concurrent update.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) upd(1'b1, 32'h500 + 32'(i * 4), 32'h5000 + 32'(i));
        look(32'h504);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h508, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 32'h500, 1'b1, 1'b1, 32'h600, 32'h6000);
        for (int i = 0; i < 3; i++) look(32'h500 + 32'(i * 4));
        look(32'h600);

        // Asynchronous reset between edges with five live entries.
        for (int i = 0; i < 5; i++) upd(1'b1, 32'h700 + 32'(i * 4), 32'h7000 + 32'(i));
        look(32'h704);
        idle();
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_ctl", bif.btb_ctl_o, 128'h0);
        chk("async_rst_occ", occ, 128'h0);
        #1;
        resetn = 1'b1;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 5; i++) look(32'h700 + 32'(i * 4));

        // Random traffic over a small PC pool so hits, evictions and bypasses recur.
        for (int n = 0; n < 3000; n++) begin
            lpc = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            upc = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 3) == 0) upc = lpc;
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), lpc,
                 1'($urandom), ($urandom_range(0, 3) != 0), upc, $urandom);
        end

        idle();
        @(posedge clk);
        #2;
        if (sb.size() != 0) chk("scoreboard_drain", 128'(sb.size()), 128'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
